lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_pkg.sv | 25 ++
 rtl/lock_timer.sv | 35 +++
 rtl/lock_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_lock_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock controller.
// The code is eight hex digits; the first digit entered is the top nibble.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROG    = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_ALARM   = 3'd5
    } state_t;

    localparam logic [4:0] KEY_START   = 5'd16;
    localparam logic [4:0] KEY_PROG    = 5'd17;
    localparam int         CODE_DIGITS = 8;

    // Digit idx is nibble [31-4*idx : 28-4*idx]; 7-idx equals ~idx in 3 bits.
    function automatic logic [3:0] code_nibble(input logic [31:0] code, input logic [2:0] idx);
        logic [31:0] sh;
        sh = code >> {~idx, 2'b00};
        return sh[3:0];
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared cycle timer: counts while enabled, clear has priority over counting.
// expire is high in the cycle where the count equals limit-1.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && (cnt_q == limit - 1'b1);

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: code entry, unlock window, reprogramming, lockout and alarm.
// Every output is a flop, so a key strobe shows its effect one cycle later.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int          MAX_TRIES   = 3,
    parameter int          TIMEOUT_CYC = 500,
    parameter int          OPEN_CYC    = 200,
    parameter int          LOCKOUT_CYC = 1000,
    parameter logic [31:0] RESET_CODE  = 32'h12345678
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [4:0] key,
    output logic       unlock,
    output logic       locked_out,
    output logic       alarm,
    output logic       prog_mode,
    output logic [3:0] digit_cnt,
    output logic [1:0] fail_cnt,
    output logic [2:0] state
);

    localparam int TMAX12 = (TIMEOUT_CYC > OPEN_CYC) ? TIMEOUT_CYC : OPEN_CYC;
    localparam int TMAX   = (TMAX12 > LOCKOUT_CYC) ? TMAX12 : LOCKOUT_CYC;
    localparam int TW     = $clog2(TMAX) + 1;
    localparam logic [1:0] MAX_F = 2'(MAX_TRIES);

    state_t        state_q, state_d;
    logic [31:0]   code_q, code_d;
    logic [27:0]   stage_q, stage_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [1:0]    fail_q, fail_d;
    logic          strike_q, strike_d, mm_q, mm_d;
    logic          unlock_q, unlock_d, locked_out_q, locked_out_d;
    logic          alarm_q, alarm_d, prog_mode_q, prog_mode_d;

    logic          key_acc, is_start, is_prog, is_digit, last_digit, digit_miss;
    logic          key_clr, tmr_clr, tmr_en, tmr_exp;
    logic [TW-1:0] tmr_limit;

    assign key_acc    = key_valid && (key <= KEY_PROG);
    assign is_start   = key_acc && (key == KEY_START);
    assign is_prog    = key_acc && (key == KEY_PROG);
    assign is_digit   = key_acc && !key[4];
    assign last_digit = (dcnt_q == 4'(CODE_DIGITS - 1));
    assign digit_miss = mm_q || (key[3:0] != code_nibble(code_q, dcnt_q[2:0]));

    assign tmr_en    = (state_q == ST_ENTRY) || (state_q == ST_PROG) ||
                       (state_q == ST_OPEN)  || (state_q == ST_LOCKOUT);
    assign tmr_limit = (state_q == ST_OPEN)    ? TW'(OPEN_CYC) :
                       (state_q == ST_LOCKOUT) ? TW'(LOCKOUT_CYC) : TW'(TIMEOUT_CYC);
    assign tmr_clr   = key_clr || (state_d != state_q);

    lock_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clr),
        .enable (tmr_en),
        .limit  (tmr_limit),
        .expire (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            code_q       <= RESET_CODE;
            stage_q      <= '0;
            dcnt_q       <= '0;
            fail_q       <= '0;
            strike_q     <= 1'b0;
            mm_q         <= 1'b0;
            unlock_q     <= 1'b0;
            locked_out_q <= 1'b0;
            alarm_q      <= 1'b0;
            prog_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            stage_q      <= stage_d;
            dcnt_q       <= dcnt_d;
            fail_q       <= fail_d;
            strike_q     <= strike_d;
            mm_q         <= mm_d;
            unlock_q     <= unlock_d;
            locked_out_q <= locked_out_d;
            alarm_q      <= alarm_d;
            prog_mode_q  <= prog_mode_d;
        end
    end

    // An accepted key is always tested before the timer, so it wins a same-cycle expiry.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        stage_d  = stage_q;
        dcnt_d   = dcnt_q;
        fail_d   = fail_q;
        strike_d = strike_q;
        mm_d     = mm_q;
        key_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_start) begin
                    state_d = ST_ENTRY;
                    dcnt_d  = '0;
                    mm_d    = 1'b0;
                end
            end
            ST_ENTRY: begin
                if (is_start) begin
                    dcnt_d  = '0;
                    mm_d    = 1'b0;
                    key_clr = 1'b1;
                end else if (is_digit) begin
                    key_clr = 1'b1;
                    dcnt_d  = dcnt_q + 4'd1;
                    mm_d    = digit_miss;
                    if (last_digit) begin
                        if (!digit_miss) begin
                            state_d  = ST_OPEN;
                            fail_d   = '0;
                            strike_d = 1'b0;
                        end else begin
                            if (fail_q != MAX_F) begin
                                fail_d = fail_q + 2'd1;
                            end
                            if (fail_d == MAX_F) begin
                                state_d = strike_q ? ST_ALARM : ST_LOCKOUT;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end else if (tmr_exp) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (is_start) begin
                    state_d = ST_IDLE;
                end else if (is_prog) begin
                    state_d = ST_PROG;
                    dcnt_d  = '0;
                    stage_d = '0;
                end else if (tmr_exp) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROG: begin
                if (is_start) begin
                    state_d = ST_IDLE;
                end else if (is_digit) begin
                    key_clr = 1'b1;
                    dcnt_d  = dcnt_q + 4'd1;
                    stage_d = {stage_q[23:0], key[3:0]};
                    if (last_digit) begin
                        code_d  = {stage_q, key[3:0]};
                        state_d = ST_IDLE;
                    end
                end else if (tmr_exp) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_exp) begin
                    state_d  = ST_IDLE;
                    fail_d   = '0;
                    strike_d = 1'b1;
                end
            end
            ST_ALARM: begin
                state_d = ST_ALARM;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        unlock_d     = (state_d == ST_OPEN);
        locked_out_d = (state_d == ST_LOCKOUT);
        alarm_d      = (state_d == ST_ALARM);
        prog_mode_d  = (state_d == ST_PROG);
    end

    assign unlock     = unlock_q;
    assign locked_out = locked_out_q;
    assign alarm      = alarm_q;
    assign prog_mode  = prog_mode_q;
    assign digit_cnt  = dcnt_q;
    assign fail_cnt   = fail_q;
    assign state      = state_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed scenarios plus random keys against a queue-based model.
module tb_lock_ctrl;
    import lock_pkg::*;

    localparam int MT = 3, TO = 20, OC = 10, LC = 30;

    logic       clk = 1'b0, rst_n = 1'b1, key_valid = 1'b0;
    logic [4:0] key = '0;
    logic       unlock, locked_out, alarm, prog_mode;
    logic [3:0] digit_cnt;
    logic [1:0] fail_cnt;
    logic [2:0] state;
    int         n_vec = 0, n_err = 0;

    lock_ctrl #(
        .MAX_TRIES(MT), .TIMEOUT_CYC(TO), .OPEN_CYC(OC), .LOCKOUT_CYC(LC),
        .RESET_CODE(32'h12345678)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key(key),
        .unlock(unlock), .locked_out(locked_out), .alarm(alarm), .prog_mode(prog_mode),
        .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: entered digits kept in a queue, timer as cycles remaining.
    state_t      m_st;
    logic [31:0] m_code;
    int          m_fail, m_rem;
    bit          m_strike;
    int          m_dig[$];

    function automatic int lim(state_t s);
        if (s == ST_OPEN) return OC;
        if (s == ST_LOCKOUT) return LC;
        return TO;
    endfunction

    function automatic logic [31:0] dig_value();
        logic [31:0] v = '0;
        foreach (m_dig[i]) v = (v << 4) | 32'(m_dig[i]);
        return v;
    endfunction

    function automatic void model_reset();
        m_st = ST_IDLE; m_code = 32'h12345678; m_fail = 0; m_strike = 0; m_rem = 0;
        m_dig.delete();
    endfunction

    function automatic void model_step(bit kv, int k);
        bit acc   = kv && (k <= 17);
        bit timed = (m_st == ST_ENTRY) || (m_st == ST_OPEN) || (m_st == ST_PROG) || (m_st == ST_LOCKOUT);
        bit expd  = timed && (m_rem == 1);
        bit rs    = 0;
        state_t nx = m_st;
        case (m_st)
            ST_IDLE: if (acc && k == 16) begin nx = ST_ENTRY; m_dig.delete(); end
            ST_ENTRY: begin
                if (acc && k == 16) begin m_dig.delete(); rs = 1; end
                else if (acc && k < 16) begin
                    m_dig.push_back(k); rs = 1;
                    if (m_dig.size() == 8) begin
                        if (dig_value() == m_code) begin nx = ST_OPEN; m_fail = 0; m_strike = 0; end
                        else begin
                            if (m_fail < MT) m_fail++;
                            nx = (m_fail == MT) ? (m_strike ? ST_ALARM : ST_LOCKOUT) : ST_IDLE;
                        end
                    end
                end else if (expd) nx = ST_IDLE;
            end
            ST_OPEN: begin
                if (acc && k == 16) nx = ST_IDLE;
                else if (acc && k == 17) begin nx = ST_PROG; m_dig.delete(); end
                else if (expd) nx = ST_IDLE;
            end
            ST_PROG: begin
                if (acc && k == 16) nx = ST_IDLE;
                else if (acc && k < 16) begin
                    m_dig.push_back(k); rs = 1;
                    if (m_dig.size() == 8) begin m_code = dig_value(); nx = ST_IDLE; end
                end else if (expd) nx = ST_IDLE;
            end
            ST_LOCKOUT: if (expd) begin nx = ST_IDLE; m_fail = 0; m_strike = 1; end
            default: ;
        endcase
        if (nx != m_st) rs = 1;
        if (rs) m_rem = lim(nx);
        else if (timed) m_rem--;
        m_st = nx;
    endfunction

    function automatic logic [8:0] obs_vec();
        return {state, unlock, locked_out, alarm, prog_mode, fail_cnt};
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [2:0] s = m_st;
        return {s, m_st == ST_OPEN, m_st == ST_LOCKOUT, m_st == ST_ALARM, m_st == ST_PROG, 2'(m_fail)};
    endfunction

    task automatic cycle(input bit kv, input int k);
        key_valid = kv; key = 5'(k);
        @(posedge clk);
        model_step(kv, k);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0; key_valid = 1'b0;
        #3 model_reset();
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic enter_code(input logic [31:0] v, input int lead);
        cycle(1, lead);
        for (int i = 7; i >= 0; i--) cycle(1, int'((v >> (4 * i)) & 32'hF));
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3 model_reset();
        n_vec++;
        if ({obs_vec(), digit_cnt} !== 13'd0) begin
            n_err++; $display("FAIL reset_state got=%h want=0", {obs_vec(), digit_cnt});
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_open();
        int hi = 1;
        apply_reset();
        enter_code(32'h12345678, 16);
        n_vec++;
        if (unlock !== 1'b1 || state !== ST_OPEN) begin
            n_err++; $display("FAIL open_after_8th unlock=%b state=%0d want 1/%0d", unlock, state, ST_OPEN);
        end
        for (int i = 0; i < 14; i++) begin
            cycle(0, $urandom_range(0, 31));
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL open_hold got=%h want=%h", obs_vec(), exp_vec());
            end
            if (unlock) hi++;
        end
        n_vec++;
        if (hi != OC || state !== ST_IDLE) begin
            n_err++; $display("FAIL open_duration got=%0d cycles state=%0d want %0d cycles IDLE", hi, state, OC);
        end
    endtask

    task automatic test_lockout();
        int lo = 1;
        apply_reset();
        for (int t = 1; t <= 3; t++) begin
            enter_code(32'h12345679, 16);
            n_vec++;
            if (t < 3 && (fail_cnt !== 2'(t) || state !== ST_IDLE)) begin
                n_err++; $display("FAIL bad_entry_%0d fail_cnt=%0d state=%0d want %0d IDLE", t, fail_cnt, state, t);
            end else if (t == 3 && locked_out !== 1'b1) begin
                n_err++; $display("FAIL lockout_enter locked_out=%b want 1", locked_out);
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (i < 29) cycle(1, $urandom_range(0, 17));
            else cycle(0, 0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL lockout_hold got=%h want=%h", obs_vec(), exp_vec());
            end
            if (locked_out) lo++;
        end
        n_vec++;
        if (lo != LC || fail_cnt !== 2'd0) begin
            n_err++; $display("FAIL lockout_len got=%0d fail=%0d want %0d fail=0", lo, fail_cnt, LC);
        end
        for (int t = 1; t <= 3; t++) enter_code(32'h87654321, 16);
        n_vec++;
        if (alarm !== 1'b1 || locked_out !== 1'b0) begin
            n_err++; $display("FAIL alarm_raise alarm=%b locked_out=%b want 1/0", alarm, locked_out);
        end
        for (int i = 0; i < 50; i++) begin
            cycle(1, $urandom_range(0, 31));
            n_vec++;
            if (alarm !== 1'b1) begin
                n_err++; $display("FAIL alarm_sticky alarm=%b want 1", alarm);
            end
        end
        apply_reset();
        n_vec++;
        if (alarm !== 1'b0 || state !== ST_IDLE) begin
            n_err++; $display("FAIL alarm_clear alarm=%b state=%0d want 0 IDLE", alarm, state);
        end
    endtask

    task automatic test_prog();
        apply_reset();
        enter_code(32'h12345678, 16);
        cycle(1, 17);
        n_vec++;
        if (prog_mode !== 1'b1 || digit_cnt !== 4'd0) begin
            n_err++; $display("FAIL prog_enter prog_mode=%b digit_cnt=%0d want 1/0", prog_mode, digit_cnt);
        end
        for (int d = 8; d >= 1; d--) cycle(1, d);
        n_vec++;
        if (state !== ST_IDLE || prog_mode !== 1'b0) begin
            n_err++; $display("FAIL prog_done state=%0d prog_mode=%b want IDLE/0", state, prog_mode);
        end
        enter_code(32'h87654321, 16);
        n_vec++;
        if (unlock !== 1'b1) begin
            n_err++; $display("FAIL new_code_opens unlock=%b want 1", unlock);
        end
        cycle(1, 16);
        n_vec++;
        if (state !== ST_IDLE || unlock !== 1'b0) begin
            n_err++; $display("FAIL manual_relock state=%0d unlock=%b want IDLE/0", state, unlock);
        end
        enter_code(32'h12345678, 16);
        n_vec++;
        if (fail_cnt !== 2'd1 || state !== ST_IDLE) begin
            n_err++; $display("FAIL old_code_rejected fail_cnt=%0d state=%0d want 1 IDLE", fail_cnt, state);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int k = 16; k <= 19; k++) cycle(1, (k == 16) ? 16 : k - 16);
        for (int i = 0; i < 19; i++) cycle(0, 0);
        n_vec++;
        if (state !== ST_ENTRY || digit_cnt !== 4'd3) begin
            n_err++; $display("FAIL timeout_early state=%0d digit_cnt=%0d want ENTRY/3", state, digit_cnt);
        end
        cycle(0, 0);
        n_vec++;
        if (state !== ST_IDLE || fail_cnt !== 2'd0) begin
            n_err++; $display("FAIL timeout_abort state=%0d fail_cnt=%0d want IDLE/0", state, fail_cnt);
        end
        for (int k = 16; k <= 19; k++) cycle(1, (k == 16) ? 16 : k - 16);
        for (int i = 0; i < 19; i++) cycle(1, 18 + i % 14);
        cycle(1, 4);
        n_vec++;
        if (state !== ST_ENTRY || digit_cnt !== 4'd4) begin
            n_err++; $display("FAIL key_beats_expiry state=%0d digit_cnt=%0d want ENTRY/4", state, digit_cnt);
        end
        for (int d = 5; d <= 8; d++) cycle(1, d);
        n_vec++;
        if (unlock !== 1'b1) begin
            n_err++; $display("FAIL resumed_entry unlock=%b want 1", unlock);
        end
    endtask

    task automatic test_reset_prog();
        apply_reset();
        enter_code(32'h12345678, 16);
        cycle(1, 17);
        for (int d = 8; d >= 4; d--) cycle(1, d);
        apply_reset();
        n_vec++;
        if (state !== ST_IDLE || prog_mode !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_prog state=%0d prog_mode=%b want IDLE/0", state, prog_mode);
        end
        enter_code(32'h12345678, 16);
        n_vec++;
        if (unlock !== 1'b1) begin
            n_err++; $display("FAIL reset_code_kept unlock=%b want 1", unlock);
        end
    endtask

    task automatic test_random();
        int alarm_cyc = 0;
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            bit kv;
            int k;
            int r;
            if (m_st == ST_ALARM) alarm_cyc++;
            if (alarm_cyc > 40 || $urandom_range(0, 599) == 0) begin
                apply_reset();
                alarm_cyc = 0;
            end
            r  = $urandom_range(0, 99);
            kv = 1;
            k  = $urandom_range(0, 31);
            if (r < 35) kv = 0;
            else if (r < 42) k = $urandom_range(18, 31);
            else if (r < 47) k = 16;
            else if (r < 50) begin
                k = 17;
                if (m_st == ST_ENTRY || m_st == ST_PROG) kv = 0;
            end else if (m_st == ST_ENTRY && $urandom_range(0, 9) < 9)
                k = int'((m_code >> (4 * (7 - m_dig.size()))) & 32'hF);
            else k = $urandom_range(0, 15);
            cycle(kv, k);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random_cycle_%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if ((m_st == ST_ENTRY || m_st == ST_PROG) && digit_cnt !== 4'(m_dig.size())) begin
                n_err++; $display("FAIL random_digits_%0d got=%0d want=%0d", c, digit_cnt, m_dig.size());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_open();
        test_lockout();
        test_prog();
        test_timeout();
        test_reset_prog();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
